message_stream_combiner_n: RTL

- Parametrised successor to the two-stream message/sample combiner.
- Merges N_STREAMS independent packetised input streams into one output stream.
- Buffers each channel and emits only complete packets, atomically, chosen by round-robin arbitration.
- Tags each output header with its source channel, and flags per-channel overflow and framing errors. Used in the qa wrappers and the main datapath after split.

---
 rtl/message_stream_combiner_n.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/message_stream_combiner_n.sv
// N-channel packet combiner: per-channel FIFO + header parser, round-robin arbiter
// that emits whole packets and tags each header with its source channel.
module message_stream_combiner_n #(
  parameter int N_STREAMS         = 2,
  parameter int LOG_N_STREAMS     = 1,
  parameter int WDTH              = 32,
  parameter int BUF_LEN           = 16,
  parameter int LOG_BUF_LEN       = 4,
  parameter int MAX_PACKET_LENGTH = 8,
  parameter int MSG_LENGTH_WIDTH  = 4,
  parameter int ID_LSB            = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_STREAMS*WDTH-1:0] in_data,
  input  logic [N_STREAMS-1:0]      in_nd,
  output logic [WDTH-1:0]           out_data,
  output logic                      out_nd,
  output logic                      error,
  output logic [N_STREAMS-1:0]      error_chan
);

  typedef enum logic [1:0] {EXPECT_HEADER, PAYLOAD, DEAD} parse_t;
  typedef enum logic {IDLE, EMIT} arb_t;

  localparam int CW = LOG_BUF_LEN + 1;
  localparam int LW = MSG_LENGTH_WIDTH + 1;
  localparam logic [MSG_LENGTH_WIDTH-1:0] MAX_LEN   = MSG_LENGTH_WIDTH'(MAX_PACKET_LENGTH);
  localparam logic [LOG_N_STREAMS-1:0]    LAST_CHAN = LOG_N_STREAMS'(N_STREAMS - 1);

  logic [WDTH-1:0]          head      [N_STREAMS];
  logic [CW-1:0]            pkt_count [N_STREAMS];
  logic [N_STREAMS-1:0]     pop, take;

  arb_t                     arb_state;
  logic [LOG_N_STREAMS-1:0] chan, last_served, sel_chan;
  logic                     sel_valid, first_word;
  logic [LW-1:0]            words_left;
  logic [WDTH-1:0]          hdr_word;

  for (genvar k = 0; k < N_STREAMS; k++) begin : g_chan
    logic [WDTH-1:0]             mem [BUF_LEN];
    logic [LOG_BUF_LEN-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]               fill, cnt;
    logic [MSG_LENGTH_WIDTH-1:0] remaining;
    parse_t                      state;
    logic                        err;
    logic [WDTH-1:0]             word;
    logic                        accept, push, completes, kill;

    assign word   = in_data[k*WDTH +: WDTH];
    // A full FIFO still takes a word if the arbiter frees a slot this cycle.
    assign accept = (fill != CW'(BUF_LEN)) || pop[k];

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
      push      = 1'b0;
      completes = 1'b0;
      kill      = 1'b0;
      if (in_nd[k]) begin
        case (state)
          EXPECT_HEADER: begin
            if (!word[WDTH-1] || word[MSG_LENGTH_WIDTH-1:0] > MAX_LEN) kill = 1'b1;
            else if (!accept) kill = 1'b1;
            else begin
              push      = 1'b1;
              completes = (word[MSG_LENGTH_WIDTH-1:0] == '0);
            end
          end
          PAYLOAD: begin
            if (!accept) kill = 1'b1;
            else begin
              push      = 1'b1;
              completes = (remaining == MSG_LENGTH_WIDTH'(1));
            end
          end
          default: ;
        endcase
      end
    end

    // NOTE: packet storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= word;
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        fill      <= '0;
        cnt       <= '0;
        remaining <= '0;
        state     <= EXPECT_HEADER;
        err       <= 1'b0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + LOG_BUF_LEN'(1);
        if (pop[k]) rd_ptr <= rd_ptr + LOG_BUF_LEN'(1);
        fill <= fill + CW'(push) - CW'(pop[k]);
        cnt  <= cnt + CW'(completes) - CW'(take[k]);
        if (kill) begin
          state <= DEAD;
          err   <= 1'b1;
        end else if (push) begin
          if (state == EXPECT_HEADER) begin
            remaining <= word[MSG_LENGTH_WIDTH-1:0];
            if (!completes) state <= PAYLOAD;
          end else begin
            remaining <= remaining - MSG_LENGTH_WIDTH'(1);
            if (completes) state <= EXPECT_HEADER;
          end
        end
      end
    end

    assign head[k]       = mem[rd_ptr];
    assign pkt_count[k]  = cnt;
    assign error_chan[k] = err;
  end

  // Round-robin scan starting just after the last channel served.
  always_comb begin
    int                       idx;
    logic [LOG_N_STREAMS-1:0] cand;
    sel_valid = 1'b0;
    sel_chan  = last_served;
    for (int i = 1; i <= N_STREAMS; i++) begin
      idx = int'(last_served) + i;
      if (idx >= N_STREAMS) idx = idx - N_STREAMS;
      cand = LOG_N_STREAMS'(idx);
      if (!sel_valid && pkt_count[cand] != '0) begin
        sel_valid = 1'b1;
        sel_chan  = cand;
      end
    end
  end

  always_comb begin
    take = '0;
    pop  = '0;
    if (arb_state == IDLE && sel_valid) take[sel_chan] = 1'b1;
    if (arb_state == EMIT)              pop[chan]      = 1'b1;
    hdr_word = head[chan];
    hdr_word[ID_LSB +: LOG_N_STREAMS] = chan;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb_state   <= IDLE;
      chan        <= '0;
      last_served <= LAST_CHAN;
      words_left  <= '0;
      first_word  <= 1'b0;
      out_data    <= '0;
      out_nd      <= 1'b0;
      error       <= 1'b0;
    end else begin
      error  <= |error_chan;
      out_nd <= 1'b0;
      case (arb_state)
        IDLE: if (sel_valid) begin
          chan       <= sel_chan;
          words_left <= LW'(head[sel_chan][MSG_LENGTH_WIDTH-1:0]) + LW'(1);
          first_word <= 1'b1;
          arb_state  <= EMIT;
        end
        EMIT: begin
          out_nd     <= 1'b1;
          out_data   <= first_word ? hdr_word : head[chan];
          first_word <= 1'b0;
          words_left <= words_left - LW'(1);
          if (words_left == LW'(1)) begin
            arb_state   <= IDLE;
            last_served <= chan;
          end
        end
        default: arb_state <= IDLE;
      endcase
    end
  end

endmodule
